axil_ctrl_master: RTL
=====================

Name: axil_ctrl_master

Overview:
- AXI4-Lite initiator that issues single register reads and writes to the per-region control slaves, such as the compression controller register file.
- Accepts one command at a time on a valid/ready command port. Drives the AXI4L master side, then returns one response per command.
- Reports resp code, read data and transaction latency in cycles.
- Used by test harnesses and the on-chip sequencer that programs vaddr and polls the TIMER_REG, PAGE_SIZE_REG and COMP_CORES_REG registers.

Parameters:
- LAT_BITS, 16: width of the saturating latency counter.
- ADDR_LSB, $clog2(AXIL_DATA_BITS/8): low address bits that must be zero (word alignment).

Ports:
- aclk  in  1  clock.
- aresetn  in  1  asynchronous active-low reset.
- cmd_valid  in  1  command valid.
- cmd_ready  out  1  command accepted when cmd_valid && cmd_ready.
- cmd_write  in  1  1 = write, 0 = read.
- cmd_addr  in  AXI_ADDR_BITS  byte address.
- cmd_wdata  in  AXIL_DATA_BITS  write data.
- cmd_wstrb  in  AXIL_DATA_BITS/8  write byte strobes.
- rsp_valid  out  1  response valid.
- rsp_ready  in  1  response consumed when rsp_valid && rsp_ready.
- rsp_write  out  1  echo of cmd_write.
- rsp_resp  out  2  bresp/rresp, or 2'b10 for a local alignment error.
- rsp_rdata  out  AXIL_DATA_BITS  read data; 0 for writes and errors.
- rsp_cycles  out  LAT_BITS  cycles from command accept to the AXI response handshake, saturating.
- axi_ctrl  AXI4L.m  –  master side: aw/w/b/ar/r channels; awprot/arprot driven 0.

Behaviour:
- Reset: asynchronous on aresetn low. FSM goes to IDLE.
  - awvalid, wvalid, bready, arvalid, rready, rsp_valid are all 0.
  - rsp_resp, rsp_rdata, rsp_cycles, rsp_write are all 0.
  - cmd_ready is 0 while aresetn is low and 1 in IDLE after release.
  - Reset mid-transaction drops all valids immediately; no response is produced for the aborted command.
- Only one command is outstanding. cmd_ready = (state == IDLE).
- Command accept registers the command, clears the latency counter to 0, then branches:
  - Misaligned (cmd_addr[ADDR_LSB-1:0] != 0) -> RESP, with rsp_resp = 2'b10, rsp_rdata = 0, rsp_cycles = 0. No AXI activity.
  - Write -> WR_REQ. awvalid and wvalid both assert in the cycle after accept. awaddr, wdata and wstrb come from registers.
  - Read -> RD_ADDR. arvalid asserts the cycle after accept.
- WR_REQ:
  - awvalid drops the cycle after its own handshake; wvalid likewise.
  - The two handshakes may occur in any order or in the same cycle.
  - Once both are done -> WR_RESP.
  - Valids never deassert before their handshake (AXI rule).
- WR_RESP:
  - bready = 1. On bvalid, capture bresp and rsp_cycles, then -> RESP. bready drops the next cycle.
- RD_ADDR:
  - arvalid held until arready. Then -> RD_DATA.
- RD_DATA:
  - rready = 1. On rvalid, capture rdata, rresp and rsp_cycles, then -> RESP.
- RESP:
  - rsp_valid = 1; response fields are stable until rsp_ready.
  - On handshake -> IDLE. cmd_ready is 1 the following cycle, so a new command can be accepted at best 1 cycle after rsp handshake.
- Latency counter:
  - Increments every cycle in WR_REQ, WR_RESP, RD_ADDR and RD_DATA.
  - Saturates at 2^LAT_BITS-1.
  - Captured value includes the handshake cycle.
- Minimum write round trip is 4 cycles and minimum read is 4 cycles with a zero-wait slave such as the controller. The controller's own 1-cycle awready/arready registration adds 1 cycle on each side.
- bvalid or rvalid arriving outside its wait state is ignored: bready and rready are 0 there.

Test Plan:
- Write addr 0x18, wdata 0xDEADBEEF, wstrb 0xFF, against a zero-wait slave -> one AW+W pair with awaddr 0x18; rsp_resp 0, rsp_write 1, rsp_rdata 0, rsp_cycles matches the measured cycle count.
- Slave gives wready 3 cycles before awready, then repeat with the reverse order -> each valid drops only after its own handshake; exactly one bready handshake; response correct in both orders.
- Read addr 0x18 against the controller with timer = 0x1234 -> rsp_rdata 0x1234, rsp_resp 0, one AR handshake.
- Write to addr 0x1C -> no AW/W/AR asserted; rsp_resp 2'b10, rsp_cycles 0, cmd_ready high again one cycle after rsp handshake.
- Hold rsp_ready low for 10 cycles after a read with rresp 2'b10 -> rsp_valid and all fields stable; cmd_ready stays 0; next command accepted only after handshake.
- Slave stalls arready for 70000 cycles -> rsp_cycles saturates at 0xFFFF. Separately, aresetn low while awvalid is high -> awvalid and wvalid are 0 immediately and no rsp_valid follows.

Source files
------------

// File: rtl/axil_ctrl_master.sv
// rtl/axil_ctrl_master.sv - single-outstanding AXI4-Lite register initiator with latency reporting
module axil_ctrl_master #(
    parameter int AXI_ADDR_BITS  = 64,
    parameter int AXIL_DATA_BITS = 64,
    parameter int LAT_BITS       = 16,
    parameter int ADDR_LSB       = $clog2(AXIL_DATA_BITS / 8)
) (
    input  logic                          aclk,
    input  logic                          aresetn,

    input  logic                          cmd_valid,
    output logic                          cmd_ready,
    input  logic                          cmd_write,
    input  logic [AXI_ADDR_BITS-1:0]      cmd_addr,
    input  logic [AXIL_DATA_BITS-1:0]     cmd_wdata,
    input  logic [AXIL_DATA_BITS/8-1:0]   cmd_wstrb,

    output logic                          rsp_valid,
    input  logic                          rsp_ready,
    output logic                          rsp_write,
    output logic [1:0]                    rsp_resp,
    output logic [AXIL_DATA_BITS-1:0]     rsp_rdata,
    output logic [LAT_BITS-1:0]           rsp_cycles,

    output logic [AXI_ADDR_BITS-1:0]      axi_ctrl_awaddr,
    output logic [2:0]                    axi_ctrl_awprot,
    output logic                          axi_ctrl_awvalid,
    input  logic                          axi_ctrl_awready,
    output logic [AXIL_DATA_BITS-1:0]     axi_ctrl_wdata,
    output logic [AXIL_DATA_BITS/8-1:0]   axi_ctrl_wstrb,
    output logic                          axi_ctrl_wvalid,
    input  logic                          axi_ctrl_wready,
    input  logic [1:0]                    axi_ctrl_bresp,
    input  logic                          axi_ctrl_bvalid,
    output logic                          axi_ctrl_bready,
    output logic [AXI_ADDR_BITS-1:0]      axi_ctrl_araddr,
    output logic [2:0]                    axi_ctrl_arprot,
    output logic                          axi_ctrl_arvalid,
    input  logic                          axi_ctrl_arready,
    input  logic [AXIL_DATA_BITS-1:0]     axi_ctrl_rdata,
    input  logic [1:0]                    axi_ctrl_rresp,
    input  logic                          axi_ctrl_rvalid,
    output logic                          axi_ctrl_rready
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_WR_REQ,
        S_WR_RESP,
        S_RD_ADDR,
        S_RD_DATA,
        S_RESP
    } state_t;

    localparam logic [1:0] RESP_SLVERR = 2'b10;

    state_t                        state;
    logic [AXI_ADDR_BITS-1:0]      addr_q;
    logic [AXIL_DATA_BITS-1:0]     wdata_q;
    logic [AXIL_DATA_BITS/8-1:0]   wstrb_q;
    logic                          aw_done;
    logic                          w_done;
    logic [LAT_BITS-1:0]           lat;
    logic [LAT_BITS-1:0]           lat_inc;

    logic misaligned;
    logic aw_hs;
    logic w_hs;
    logic aw_fin;
    logic w_fin;

    assign misaligned = |cmd_addr[ADDR_LSB-1:0];
    assign aw_hs      = axi_ctrl_awvalid && axi_ctrl_awready;
    assign w_hs       = axi_ctrl_wvalid && axi_ctrl_wready;
    assign aw_fin     = aw_done || aw_hs;
    assign w_fin      = w_done || w_hs;

    // Saturating increment; the captured latency includes the handshake cycle.
    assign lat_inc = (lat == {LAT_BITS{1'b1}}) ? lat : lat + LAT_BITS'(1);

    assign axi_ctrl_awaddr = addr_q;
    assign axi_ctrl_araddr = addr_q;
    assign axi_ctrl_wdata  = wdata_q;
    assign axi_ctrl_wstrb  = wstrb_q;
    assign axi_ctrl_awprot = 3'b000;
    assign axi_ctrl_arprot = 3'b000;

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state            <= S_IDLE;
            cmd_ready        <= 1'b0;
            addr_q           <= '0;
            wdata_q          <= '0;
            wstrb_q          <= '0;
            aw_done          <= 1'b0;
            w_done           <= 1'b0;
            lat              <= '0;
            axi_ctrl_awvalid <= 1'b0;
            axi_ctrl_wvalid  <= 1'b0;
            axi_ctrl_bready  <= 1'b0;
            axi_ctrl_arvalid <= 1'b0;
            axi_ctrl_rready  <= 1'b0;
            rsp_valid        <= 1'b0;
            rsp_write        <= 1'b0;
            rsp_resp         <= 2'b00;
            rsp_rdata        <= '0;
            rsp_cycles       <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (cmd_valid && cmd_ready) begin
                        cmd_ready <= 1'b0;
                        addr_q    <= cmd_addr;
                        wdata_q   <= cmd_wdata;
                        wstrb_q   <= cmd_wstrb;
                        lat       <= '0;
                        if (misaligned) begin
                            state      <= S_RESP;
                            rsp_valid  <= 1'b1;
                            rsp_write  <= cmd_write;
                            rsp_resp   <= RESP_SLVERR;
                            rsp_rdata  <= '0;
                            rsp_cycles <= '0;
                        end else if (cmd_write) begin
                            state            <= S_WR_REQ;
                            axi_ctrl_awvalid <= 1'b1;
                            axi_ctrl_wvalid  <= 1'b1;
                            aw_done          <= 1'b0;
                            w_done           <= 1'b0;
                        end else begin
                            state            <= S_RD_ADDR;
                            axi_ctrl_arvalid <= 1'b1;
                        end
                    end else begin
                        cmd_ready <= 1'b1;
                    end
                end

                // AW and W complete independently, in either order or together.
                S_WR_REQ: begin
                    lat <= lat_inc;
                    if (aw_hs) begin
                        axi_ctrl_awvalid <= 1'b0;
                        aw_done          <= 1'b1;
                    end
                    if (w_hs) begin
                        axi_ctrl_wvalid <= 1'b0;
                        w_done          <= 1'b1;
                    end
                    if (aw_fin && w_fin) begin
                        state           <= S_WR_RESP;
                        axi_ctrl_bready <= 1'b1;
                    end
                end

                S_WR_RESP: begin
                    lat <= lat_inc;
                    if (axi_ctrl_bvalid && axi_ctrl_bready) begin
                        axi_ctrl_bready <= 1'b0;
                        state           <= S_RESP;
                        rsp_valid       <= 1'b1;
                        rsp_write       <= 1'b1;
                        rsp_resp        <= axi_ctrl_bresp;
                        rsp_rdata       <= '0;
                        rsp_cycles      <= lat_inc;
                    end
                end

                S_RD_ADDR: begin
                    lat <= lat_inc;
                    if (axi_ctrl_arvalid && axi_ctrl_arready) begin
                        axi_ctrl_arvalid <= 1'b0;
                        axi_ctrl_rready  <= 1'b1;
                        state            <= S_RD_DATA;
                    end
                end

                S_RD_DATA: begin
                    lat <= lat_inc;
                    if (axi_ctrl_rvalid && axi_ctrl_rready) begin
                        axi_ctrl_rready <= 1'b0;
                        state           <= S_RESP;
                        rsp_valid       <= 1'b1;
                        rsp_write       <= 1'b0;
                        rsp_resp        <= axi_ctrl_rresp;
                        rsp_rdata       <= axi_ctrl_rdata;
                        rsp_cycles      <= lat_inc;
                    end
                end

                // Response fields hold until consumed; cmd_ready returns with IDLE.
                S_RESP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        cmd_ready <= 1'b1;
                        state     <= S_IDLE;
                    end
                end

                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule
